// File: rtl/gsau_dispatch.sv
// gsau_dispatch: sequences weight loads and activation/partial pairs into the systolic array and returns tagged results
module gsau_dispatch #(
    parameter int TAG_DEPTH = 4,
    parameter int WROWS     = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         issue_valid,
    input  logic         issue_weight,
    input  logic [7:0]   issue_vdst,
    output logic         issue_ready,
    input  logic [511:0] veg_vdata,
    input  logic         veg_valid,
    output logic         veg_ready,
    output logic [511:0] sa_array_in,
    output logic [511:0] sa_array_in_partials,
    output logic         sa_input_en,
    output logic         sa_weight_en,
    output logic         sa_partial_en,
    input  logic         sa_fifo_has_space,
    input  logic [511:0] sa_array_output,
    input  logic         sa_out_en,
    output logic [511:0] wb_psum,
    output logic [7:0]   wb_wbdst,
    output logic         wb_valid,
    input  logic         wb_output_ready,
    output logic         busy,
    output logic         err_spurious
);
    localparam int AW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);
    localparam int BW = WROWS > 1 ? $clog2(WROWS) : 1;
    localparam logic [CW:0]   W_FULL = (CW + 1)'(TAG_DEPTH);
    localparam logic [AW-1:0] W_LAST_PTR = AW'(TAG_DEPTH - 1);
    localparam logic [BW-1:0] W_LAST_BEAT = BW'(WROWS - 1);

    typedef enum logic [2:0] {IDLE, WLOAD, ACT_A, ACT_P, FIRE} state_t;

    state_t         r_state, w_next;
    logic [BW-1:0]  r_beat;
    logic [511:0]   r_act, r_part;
    logic [7:0]     r_vdst;
    logic           r_err;
    logic [7:0]     r_tag_mem [TAG_DEPTH];
    logic [AW-1:0]  r_tag_rd, r_tag_wr;
    logic [CW-1:0]  r_tag_cnt;
    logic [519:0]   r_ob_mem [TAG_DEPTH];
    logic [AW-1:0]  r_ob_rd, r_ob_wr;
    logic [CW-1:0]  r_ob_cnt;

    logic [CW:0]    w_credits;
    logic           w_issue, w_tag_push, w_tag_pop, w_ob_pop;

    // credits cover every result still owed to writeback, so the output buffer can never overflow
    assign w_credits  = (CW + 1)'(r_tag_cnt) + (CW + 1)'(r_ob_cnt);
    assign w_issue    = issue_valid && issue_ready;
    assign w_tag_push = (r_state == FIRE) && sa_fifo_has_space;
    assign w_tag_pop  = sa_out_en && (r_tag_cnt != '0);
    assign w_ob_pop   = wb_valid && wb_output_ready;

    assign wb_valid     = r_ob_cnt != '0;
    assign wb_psum      = wb_valid ? r_ob_mem[r_ob_rd][519:8] : '0;
    assign wb_wbdst     = wb_valid ? r_ob_mem[r_ob_rd][7:0] : '0;
    assign busy         = (r_state != IDLE) || (w_credits != '0);
    assign err_spurious = r_err;

    // next state and array drive; everything idles at zero unless a state claims it
    always_comb begin
        w_next               = r_state;
        issue_ready          = 1'b0;
        veg_ready            = 1'b0;
        sa_array_in          = '0;
        sa_array_in_partials = '0;
        sa_input_en          = 1'b0;
        sa_weight_en         = 1'b0;
        sa_partial_en        = 1'b0;
        case (r_state)
            IDLE: begin
                issue_ready = issue_weight ? (w_credits == '0) : (w_credits < W_FULL);
                if (issue_valid && issue_ready) w_next = issue_weight ? WLOAD : ACT_A;
            end
            WLOAD: begin
                veg_ready    = 1'b1;
                sa_array_in  = veg_vdata;
                sa_weight_en = veg_valid;
                if (veg_valid && r_beat == W_LAST_BEAT) w_next = IDLE;
            end
            ACT_A: begin
                veg_ready = 1'b1;
                if (veg_valid) w_next = ACT_P;
            end
            ACT_P: begin
                veg_ready = 1'b1;
                if (veg_valid) w_next = FIRE;
            end
            FIRE: begin
                sa_array_in          = r_act;
                sa_array_in_partials = r_part;
                sa_input_en          = sa_fifo_has_space;
                sa_partial_en        = sa_fifo_has_space;
                if (sa_fifo_has_space) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state, beat counter, operand latches and sticky spurious-result flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_act   <= '0;
            r_part  <= '0;
            r_vdst  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_issue) r_beat <= '0;
            else if (r_state == WLOAD && veg_valid) r_beat <= r_beat + 1'b1;
            if (w_issue && !issue_weight) r_vdst <= issue_vdst;
            if (r_state == ACT_A && veg_valid) r_act <= veg_vdata;
            if (r_state == ACT_P && veg_valid) r_part <= veg_vdata;
            if (sa_out_en && r_tag_cnt == '0) r_err <= 1'b1;
        end
    end

    // tag and output buffer pointers; push and pop may coincide, leaving the count unchanged
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tag_rd  <= '0;
            r_tag_wr  <= '0;
            r_tag_cnt <= '0;
            r_ob_rd   <= '0;
            r_ob_wr   <= '0;
            r_ob_cnt  <= '0;
        end else begin
            if (w_tag_push) r_tag_wr <= (r_tag_wr == W_LAST_PTR) ? '0 : r_tag_wr + 1'b1;
            if (w_tag_pop) r_tag_rd <= (r_tag_rd == W_LAST_PTR) ? '0 : r_tag_rd + 1'b1;
            r_tag_cnt <= r_tag_cnt + CW'(w_tag_push) - CW'(w_tag_pop);
            if (w_tag_pop) r_ob_wr <= (r_ob_wr == W_LAST_PTR) ? '0 : r_ob_wr + 1'b1;
            if (w_ob_pop) r_ob_rd <= (r_ob_rd == W_LAST_PTR) ? '0 : r_ob_rd + 1'b1;
            r_ob_cnt <= r_ob_cnt + CW'(w_tag_pop) - CW'(w_ob_pop);
        end
    end

    // storage arrays need no reset: reads are gated by the counts
    always_ff @(posedge CLK) begin
        if (w_tag_push) r_tag_mem[r_tag_wr] <= r_vdst;
        if (w_tag_pop) r_ob_mem[r_ob_wr] <= {sa_array_output, r_tag_mem[r_tag_rd]};
    end
endmodule

// File: tb/tb_gsau_dispatch.sv
// tb_gsau_dispatch: scenario tasks with a queue scoreboard for gsau_dispatch
module tb_gsau_dispatch;
    logic         CLK, RST;
    logic         issue_valid, issue_weight, issue_ready;
    logic [7:0]   issue_vdst;
    logic [511:0] veg_vdata;
    logic         veg_valid, veg_ready;
    logic [511:0] sa_array_in, sa_array_in_partials, sa_array_output;
    logic         sa_input_en, sa_weight_en, sa_partial_en, sa_fifo_has_space, sa_out_en;
    logic [511:0] wb_psum;
    logic [7:0]   wb_wbdst;
    logic         wb_valid, wb_output_ready, busy, err_spurious;

    int checks = 0;
    int errors = 0;
    logic [511:0] wq [$];
    logic [519:0] rq [$];

    gsau_dispatch dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_weight(issue_weight), .issue_vdst(issue_vdst), .issue_ready(issue_ready),
        .veg_vdata(veg_vdata), .veg_valid(veg_valid), .veg_ready(veg_ready),
        .sa_array_in(sa_array_in), .sa_array_in_partials(sa_array_in_partials),
        .sa_input_en(sa_input_en), .sa_weight_en(sa_weight_en), .sa_partial_en(sa_partial_en),
        .sa_fifo_has_space(sa_fifo_has_space),
        .sa_array_output(sa_array_output), .sa_out_en(sa_out_en),
        .wb_psum(wb_psum), .wb_wbdst(wb_wbdst), .wb_valid(wb_valid), .wb_output_ready(wb_output_ready),
        .busy(busy), .err_spurious(err_spurious)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_act(input logic [7:0] vdst);
        issue_valid = 1'b1; issue_weight = 1'b0; issue_vdst = vdst;
        tick();
        issue_valid = 1'b0; veg_valid = 1'b1; veg_vdata = rand512();
        tick();
        veg_vdata = rand512();
        tick();
        veg_valid = 1'b0; sa_fifo_has_space = 1'b1;
        tick();
        sa_fifo_has_space = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready got %b exp 1", issue_ready); end
        checks++; if ({veg_ready, sa_input_en, sa_weight_en, sa_partial_en, wb_valid, busy, err_spurious} !== 7'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000000", {veg_ready, sa_input_en, sa_weight_en, sa_partial_en, wb_valid, busy, err_spurious}); end
        checks++; if ({sa_array_in, sa_array_in_partials, wb_psum, wb_wbdst} !== '0) begin errors++; $display("FAIL rst_data got nonzero exp 0"); end
        tick();
        RST = 1'b0;
    endtask

    task automatic test_weight_load();
        logic [511:0] exp;
        int pulses = 0;
        issue_valid = 1'b1; issue_weight = 1'b1; issue_vdst = 8'h00;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL wl_issue_ready got %b exp 1", issue_ready); end
        tick();
        issue_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            veg_vdata = 512'(i); veg_valid = 1'b1; wq.push_back(512'(i));
            #1;
            exp = wq.pop_front();
            if (sa_weight_en === 1'b1) pulses++;
            checks++; if (sa_array_in !== exp || veg_ready !== 1'b1) begin errors++; $display("FAIL wl_beat%0d got %h rdy %b exp %h rdy 1", i, sa_array_in, veg_ready, exp); end
            tick();
        end
        veg_valid = 1'b0;
        #1;
        checks++; if (pulses != 16) begin errors++; $display("FAIL wl_pulses got %0d exp 16", pulses); end
        checks++; if (issue_ready !== 1'b1 || busy !== 1'b0 || veg_ready !== 1'b0) begin errors++; $display("FAIL wl_done got ready %b busy %b veg_ready %b exp 1 0 0", issue_ready, busy, veg_ready); end
    endtask

    task automatic test_act_stall();
        logic [519:0] exp;
        logic [511:0] a = {64{8'hAA}};
        logic [511:0] p = {64{8'h55}};
        logic [511:0] r = rand512();
        issue_valid = 1'b1; issue_weight = 1'b0; issue_vdst = 8'h05;
        tick();
        issue_valid = 1'b0; veg_valid = 1'b1; veg_vdata = a;
        tick();
        veg_vdata = p;
        tick();
        veg_valid = 1'b0; sa_fifo_has_space = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({sa_input_en, sa_partial_en, veg_ready, busy} !== 4'b0001) begin errors++; $display("FAIL act_stall%0d got %b exp 0001", i, {sa_input_en, sa_partial_en, veg_ready, busy}); end
            tick();
        end
        sa_fifo_has_space = 1'b1;
        #1;
        checks++; if (sa_input_en !== 1'b1 || sa_partial_en !== 1'b1) begin errors++; $display("FAIL act_fire_en got %b%b exp 11", sa_input_en, sa_partial_en); end
        checks++; if (sa_array_in !== a || sa_array_in_partials !== p) begin errors++; $display("FAIL act_fire_data got %h / %h exp %h / %h", sa_array_in[31:0], sa_array_in_partials[31:0], a[31:0], p[31:0]); end
        tick();
        sa_fifo_has_space = 1'b0;
        #1;
        checks++; if (sa_input_en !== 1'b0 || busy !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL act_after got en %b busy %b wbv %b exp 0 1 0", sa_input_en, busy, wb_valid); end
        sa_out_en = 1'b1; sa_array_output = r; rq.push_back({r, 8'h05});
        tick();
        sa_out_en = 1'b0;
        #1;
        exp = rq.pop_front();
        checks++; if (wb_valid !== 1'b1 || {wb_psum, wb_wbdst} !== exp) begin errors++; $display("FAIL act_wb got v %b dst %h exp v 1 dst %h", wb_valid, wb_wbdst, exp[7:0]); end
        wb_output_ready = 1'b1;
        tick();
        wb_output_ready = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL act_drain got v %b busy %b exp 0 0", wb_valid, busy); end
    endtask

    task automatic test_credit_limit();
        logic [519:0] exp;
        logic [511:0] r;
        for (int v = 1; v <= 4; v++) do_act(8'(v));
        issue_valid = 1'b1; issue_weight = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL cr_act5 got %b exp 0", issue_ready); end
        issue_weight = 1'b1;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL cr_weight got %b exp 0", issue_ready); end
        issue_valid = 1'b0; issue_weight = 1'b0;
        r = rand512(); sa_out_en = 1'b1; sa_array_output = r; rq.push_back({r, 8'd1});
        tick();
        sa_out_en = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL cr_before_pop got %b exp 0", issue_ready); end
        wb_output_ready = 1'b1;
        #1;
        exp = rq.pop_front();
        checks++; if (wb_valid !== 1'b1 || {wb_psum, wb_wbdst} !== exp) begin errors++; $display("FAIL cr_wb1 got dst %h exp %h", wb_wbdst, exp[7:0]); end
        tick();
        wb_output_ready = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL cr_released got %b exp 1", issue_ready); end
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                r = rand512(); sa_out_en = 1'b1; sa_array_output = r; rq.push_back({r, 8'(2 + k)});
            end else sa_out_en = 1'b0;
            wb_output_ready = 1'b1;
            #1;
            if (k > 0) begin
                exp = rq.pop_front();
                checks++; if (wb_valid !== 1'b1 || {wb_psum, wb_wbdst} !== exp) begin errors++; $display("FAIL cr_pushpop%0d got v %b dst %h exp v 1 dst %h", k, wb_valid, wb_wbdst, exp[7:0]); end
            end
            tick();
        end
        wb_output_ready = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cr_empty got v %b busy %b exp 0 0", wb_valid, busy); end
    endtask

    task automatic test_wb_order();
        logic [519:0] exp;
        logic [511:0] r;
        do_act(8'd7); do_act(8'd8); do_act(8'd9);
        wb_output_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r = rand512(); sa_out_en = 1'b1; sa_array_output = r; rq.push_back({r, 8'(7 + i)});
            tick();
        end
        sa_out_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = rq[0];
            checks++; if (wb_valid !== 1'b1 || {wb_psum, wb_wbdst} !== exp) begin errors++; $display("FAIL wbo_hold%0d got v %b dst %h exp v 1 dst %h", i, wb_valid, wb_wbdst, exp[7:0]); end
            tick();
        end
        wb_output_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = rq.pop_front();
            checks++; if (wb_valid !== 1'b1 || {wb_psum, wb_wbdst} !== exp) begin errors++; $display("FAIL wbo_pop%0d got v %b dst %h exp v 1 dst %h", i, wb_valid, wb_wbdst, exp[7:0]); end
            tick();
        end
        wb_output_ready = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wbo_empty got v %b busy %b exp 0 0", wb_valid, busy); end
    endtask

    task automatic test_spurious();
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL sp_pre got %b exp 0", err_spurious); end
        sa_out_en = 1'b1; sa_array_output = rand512();
        tick();
        sa_out_en = 1'b0;
        tick();
        checks++; if (err_spurious !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL sp_set got err %b wbv %b exp 1 0", err_spurious, wb_valid); end
        RST = 1'b1;
        #1;
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL sp_clear got %b exp 0", err_spurious); end
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_weight = 1'b1;
        tick();
        issue_valid = 1'b0; veg_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            veg_vdata = 512'(i);
            tick();
        end
        veg_vdata = 512'(6); RST = 1'b1;
        #1;
        checks++; if ({sa_weight_en, veg_ready, busy} !== 3'b000 || sa_array_in !== '0) begin errors++; $display("FAIL rm_outputs got %b exp 000", {sa_weight_en, veg_ready, busy}); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rm_issue_ready got %b exp 1", issue_ready); end
        tick();
        RST = 1'b0;
        tick();
        checks++; if ({sa_weight_en, sa_input_en, sa_partial_en, veg_ready} !== 4'b0) begin errors++; $display("FAIL rm_no_pulse got %b exp 0000", {sa_weight_en, sa_input_en, sa_partial_en, veg_ready}); end
        veg_valid = 1'b0;
        test_weight_load();
    endtask

    initial begin
        RST = 1'b1; issue_valid = 1'b0; issue_weight = 1'b0; issue_vdst = '0;
        veg_vdata = '0; veg_valid = 1'b0; sa_fifo_has_space = 1'b0;
        sa_array_output = '0; sa_out_en = 1'b0; wb_output_ready = 1'b0;
        test_reset();
        test_weight_load();
        test_act_stall();
        test_credit_limit();
        test_wb_order();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
